// File: rtl/ycr_dmem_wb_arb_if.sv
// Wishbone master bus for ycr_dmem_wb_arb.
// Carries the burst-capable Wishbone signals between the bridge and a slave.
//   master: drives cyc/stb/we/adr/dat_o/sel/bl/bry, receives dat_i/ack/lack/err
//   slave : the mirror image of master
interface ycr_dmem_wb_arb_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned BLW = 3
);
    logic           wbd_cyc_o;
    logic           wbd_stb_o;
    logic           wbd_we_o;
    logic [AW-1:0]  wbd_adr_o;
    logic [DW-1:0]  wbd_dat_o;
    logic [3:0]     wbd_sel_o;
    logic [BLW-1:0] wbd_bl_o;
    logic           wbd_bry_o;
    logic [DW-1:0]  wbd_dat_i;
    logic           wbd_ack_i;
    logic           wbd_lack_i;
    logic           wbd_err_i;

    modport master (
        output wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o,
        output wbd_bry_o,
        input  wbd_dat_i, wbd_ack_i, wbd_lack_i, wbd_err_i
    );

    modport slave (
        input  wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o,
        input  wbd_bry_o,
        output wbd_dat_i, wbd_ack_i, wbd_lack_i, wbd_err_i
    );
endinterface

// File: rtl/ycr_dmem_wb_arb.sv
// Multi-channel data-memory to Wishbone bridge.
// Round-robin arbitration over NCH core request channels, alignment pre-checks,
// byte-lane generation, burst reads and a bus timeout, single clock domain.
// Ports:
//   core_clk, core_rst_n : clock, asynchronous active-low reset
//   core_dmem_*          : per-channel request side (req/cmd/width/addr/bl/wdata in,
//                          req_ack/resp out, shared rdata out)
//   wbd                  : Wishbone master bus (see ycr_dmem_wb_arb_if)
module ycr_dmem_wb_arb #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned BLW   = 3,
    parameter int unsigned TMO_W = 8
) (
    input  logic               core_clk,
    input  logic               core_rst_n,
    input  logic [NCH-1:0]     core_dmem_req,
    input  logic [NCH-1:0]     core_dmem_cmd,
    input  logic [2*NCH-1:0]   core_dmem_width,
    input  logic [AW*NCH-1:0]  core_dmem_addr,
    input  logic [BLW*NCH-1:0] core_dmem_bl,
    input  logic [DW*NCH-1:0]  core_dmem_wdata,
    output logic [NCH-1:0]     core_dmem_req_ack,
    output logic [DW-1:0]      core_dmem_rdata,
    output logic [2*NCH-1:0]   core_dmem_resp,
    ycr_dmem_wb_arb_if.master  wbd
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (TMO_W > 0) ? TMO_W : 1;

    localparam logic [1:0] RespOk  = 2'b01;
    localparam logic [1:0] RespErr = 2'b10;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e                  state_q;
    logic [PW-1:0]           ptr_q;
    logic [PW-1:0]           gnt_q;
    logic [CW-1:0]           tmo_q;
    logic [NCH-1:0]          req_ack_q;
    logic [NCH-1:0][1:0]     resp_q;
    logic [DW-1:0]           rdata_q;
    logic                    cyc_q, stb_q, we_q, bry_q;
    logic [AW-1:0]           adr_q;
    logic [DW-1:0]           dat_q;
    logic [3:0]              sel_q;
    logic [BLW-1:0]          bl_q;

    // Winner selection and field mux of the winning channel.
    logic                    found;
    logic [PW-1:0]           win;
    logic                    w_cmd;
    logic [1:0]              w_width;
    logic [AW-1:0]           w_addr;
    logic [BLW-1:0]          w_bl;
    logic [DW-1:0]           w_wdata;
    int                      idx;

    always_comb begin
        found   = 1'b0;
        win     = '0;
        w_cmd   = 1'b0;
        w_width = '0;
        w_addr  = '0;
        w_bl    = '0;
        w_wdata = '0;
        idx     = 0;
        // Walk from the lowest priority offset down so the closest requester to ptr wins.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % int'(NCH);
            if (core_dmem_req[idx]) begin
                found   = 1'b1;
                win     = PW'(idx);
                w_cmd   = core_dmem_cmd[idx];
                w_width = core_dmem_width[2*idx +: 2];
                w_addr  = core_dmem_addr[AW*idx +: AW];
                w_bl    = core_dmem_bl[BLW*idx +: BLW];
                w_wdata = core_dmem_wdata[DW*idx +: DW];
            end
        end
    end

    logic           w_bad;
    logic [3:0]     w_sel;
    logic [BLW-1:0] w_bl_eff;

    always_comb begin
        w_bad = (w_width == 2'b11) ||
                (w_width == 2'b01 && w_addr[0]) ||
                (w_width == 2'b10 && w_addr[1:0] != 2'b00);
        case (w_width)
            2'b00:   w_sel = 4'b0001 << w_addr[1:0];
            2'b01:   w_sel = 4'b0011 << {w_addr[1], 1'b0};
            default: w_sel = 4'hF;
        endcase
        // Writes are always single beat; a zero read length means one beat.
        if (w_cmd || w_bl == '0) begin
            w_bl_eff = BLW'(1);
        end else begin
            w_bl_eff = w_bl;
        end
    end

    logic          ack_evt;
    logic [CW-1:0] tmo_nxt;
    logic          tmo_hit;

    always_comb begin
        ack_evt = wbd.wbd_ack_i | wbd.wbd_lack_i;
        tmo_nxt = tmo_q + 1'b1;
        tmo_hit = (TMO_W != 0) && (tmo_nxt == '1);
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            tmo_q     <= '0;
            req_ack_q <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            bry_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            bl_q      <= '0;
        end else begin
            req_ack_q <= '0;
            resp_q    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        gnt_q          <= win;
                        ptr_q          <= (int'(win) == int'(NCH) - 1) ? '0 : win + 1'b1;
                        req_ack_q[win] <= 1'b1;
                        we_q           <= w_cmd;
                        adr_q          <= {w_addr[AW-1:2], 2'b00};
                        dat_q          <= w_wdata;
                        sel_q          <= w_sel;
                        bl_q           <= w_bl_eff;
                        tmo_q          <= '0;
                        if (w_bad) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StBus;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            bry_q   <= 1'b1;
                        end
                    end
                end
                StBus: begin
                    if (wbd.wbd_err_i) begin
                        resp_q[gnt_q] <= RespErr;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        bry_q         <= 1'b0;
                        state_q       <= StIdle;
                    end else if (ack_evt) begin
                        resp_q[gnt_q] <= RespOk;
                        tmo_q         <= '0;
                        if (!we_q) begin
                            rdata_q <= wbd.wbd_dat_i;
                        end
                        if (wbd.wbd_lack_i || bl_q == BLW'(1)) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            bry_q   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else if (tmo_hit) begin
                        resp_q[gnt_q] <= RespErr;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        bry_q         <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        tmo_q <= tmo_nxt;
                    end
                end
                StResp: begin
                    resp_q[gnt_q] <= RespErr;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_dmem_req_ack = req_ack_q;
    assign core_dmem_rdata   = rdata_q;
    assign core_dmem_resp    = resp_q;
    assign wbd.wbd_cyc_o     = cyc_q;
    assign wbd.wbd_stb_o     = stb_q;
    assign wbd.wbd_we_o      = we_q;
    assign wbd.wbd_adr_o     = adr_q;
    assign wbd.wbd_dat_o     = dat_q;
    assign wbd.wbd_sel_o     = sel_q;
    assign wbd.wbd_bl_o      = bl_q;
    assign wbd.wbd_bry_o     = bry_q;

endmodule

// File: tb/tb_ycr_dmem_wb_arb.sv
// Self-checking bench for ycr_dmem_wb_arb: directed scenarios followed by random
// transactions, checked against a transaction-level model of arbitration, lane
// select, alignment, burst length, response timing and timeout.
module tb_ycr_dmem_wb_arb;
    localparam int unsigned NCH   = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BLW   = 3;
    localparam int unsigned TMO_W = 4;
    localparam int TmoCycles = (1 << TMO_W) - 1;

    logic               core_clk = 1'b0;
    logic               core_rst_n;
    logic [NCH-1:0]     core_dmem_req;
    logic [NCH-1:0]     core_dmem_cmd;
    logic [2*NCH-1:0]   core_dmem_width;
    logic [AW*NCH-1:0]  core_dmem_addr;
    logic [BLW*NCH-1:0] core_dmem_bl;
    logic [DW*NCH-1:0]  core_dmem_wdata;
    logic [NCH-1:0]     core_dmem_req_ack;
    logic [DW-1:0]      core_dmem_rdata;
    logic [2*NCH-1:0]   core_dmem_resp;

    ycr_dmem_wb_arb_if #(.AW(AW), .DW(DW), .BLW(BLW)) wbd ();

    ycr_dmem_wb_arb #(
        .NCH(NCH), .AW(AW), .DW(DW), .BLW(BLW), .TMO_W(TMO_W)
    ) dut (
        .core_clk          (core_clk),
        .core_rst_n        (core_rst_n),
        .core_dmem_req     (core_dmem_req),
        .core_dmem_cmd     (core_dmem_cmd),
        .core_dmem_width   (core_dmem_width),
        .core_dmem_addr    (core_dmem_addr),
        .core_dmem_bl      (core_dmem_bl),
        .core_dmem_wdata   (core_dmem_wdata),
        .core_dmem_req_ack (core_dmem_req_ack),
        .core_dmem_rdata   (core_dmem_rdata),
        .core_dmem_resp    (core_dmem_resp),
        .wbd               (wbd)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_errors = 0;
    int rr_ptr   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_sel(input logic [1:0] w, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (w == 2'd0) return 4'(1 << off);
        if (w == 2'd1) return 4'(3 << ((off / 2) * 2));
        return 4'hF;
    endfunction

    function automatic bit exp_bad(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd3) || (w == 2'd1 && a % 32'd2 != 0) || (w == 2'd2 && a % 32'd4 != 0);
    endfunction

    task automatic set_req(input int c, input logic wr, input logic [1:0] w,
                           input logic [31:0] a, input logic [BLW-1:0] b, input logic [31:0] wd);
        core_dmem_req[c]             = 1'b1;
        core_dmem_cmd[c]             = wr;
        core_dmem_width[2*c +: 2]    = w;
        core_dmem_addr[AW*c +: AW]   = a;
        core_dmem_bl[BLW*c +: BLW]   = b;
        core_dmem_wdata[DW*c +: DW]  = wd;
    endtask

    task automatic rand_req(input int c);
        int          r;
        logic [1:0]  w;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        w = (r == 9) ? 2'd3 : 2'(r % 3);
        a = $urandom;
        if ($urandom_range(0, 4) != 0) begin
            if (w == 2'd1) a = a - (a % 32'd2);
            if (w == 2'd2) a = a - (a % 32'd4);
        end
        set_req(c, 1'($urandom_range(0, 1)), w, a, BLW'($urandom_range(0, 7)), $urandom);
    endtask

    // scen: 0 normal, 1 bus error (err_beat, 0 = random beat), 2 slave never acks.
    // dly: idle cycles before each beat (<0 = random). first_rd: beat-1 data when nonzero.
    task automatic run_txn(input int scen, input int err_beat, input int dly,
                           input logic [31:0] first_rd);
        int             g, c, nb, d, n, eb;
        logic           wr;
        logic [1:0]     w;
        logic [31:0]    a, wd, rd;
        logic [BLW-1:0] b;
        bit             bad, is_err;
        g = -1;
        for (int off = 0; off < int'(NCH); off++) begin
            c = (rr_ptr + off) % int'(NCH);
            if (g < 0 && core_dmem_req[c]) g = c;
        end
        if (g < 0) return;
        wr  = core_dmem_cmd[g];
        w   = core_dmem_width[2*g +: 2];
        a   = core_dmem_addr[AW*g +: AW];
        b   = core_dmem_bl[BLW*g +: BLW];
        wd  = core_dmem_wdata[DW*g +: DW];
        bad = exp_bad(w, a);
        nb  = (wr || b == 0) ? 1 : int'(b);
        rr_ptr = (g + 1) % int'(NCH);

        @(posedge core_clk); #1;
        check_val("req_ack", 64'(core_dmem_req_ack), 64'(1 << g));
        check_val("resp_clear", 64'(core_dmem_resp), 64'(0));
        core_dmem_req[g] = 1'b0;
        if (bad) begin
            check_val("cyc_on_bad", 64'(wbd.wbd_cyc_o), 64'(0));
            @(posedge core_clk); #1;
            check_val("resp_bad", 64'(core_dmem_resp), 64'(2 << (2 * g)));
            check_val("cyc_after_bad", 64'(wbd.wbd_cyc_o), 64'(0));
            return;
        end
        check_val("cyc_stb_bry", 64'({wbd.wbd_cyc_o, wbd.wbd_stb_o, wbd.wbd_bry_o}), 64'(7));
        check_val("we", 64'(wbd.wbd_we_o), 64'(wr));
        check_val("adr", 64'(wbd.wbd_adr_o), 64'(a - (a % 32'd4)));
        check_val("sel", 64'(wbd.wbd_sel_o), 64'(exp_sel(w, a)));
        check_val("bl", 64'(wbd.wbd_bl_o), 64'(nb));
        if (wr) check_val("dat_o", 64'(wbd.wbd_dat_o), 64'(wd));

        if (scen == 2) begin
            n = 0;
            while (wbd.wbd_cyc_o === 1'b1 && n < 64) begin
                n++;
                @(posedge core_clk); #1;
            end
            check_val("tmo_cycles", 64'(n), 64'(TmoCycles));
            check_val("tmo_resp", 64'(core_dmem_resp), 64'(2 << (2 * g)));
            return;
        end

        eb = 0;
        if (scen == 1) eb = (err_beat > 0 && err_beat <= nb) ? err_beat :
                            int'($urandom_range(1, nb));
        for (int k = 1; k <= nb; k++) begin
            d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
            repeat (d) begin
                @(posedge core_clk); #1;
                check_val("resp_wait", 64'(core_dmem_resp), 64'(0));
                check_val("cyc_wait", 64'(wbd.wbd_cyc_o), 64'(1));
            end
            rd = (k == 1 && first_rd != 0) ? first_rd : $urandom;
            wbd.wbd_dat_i = rd;
            is_err = (k == eb);
            if (is_err) begin
                wbd.wbd_err_i = 1'b1;
                wbd.wbd_ack_i = 1'($urandom_range(0, 1));
            end else begin
                wbd.wbd_ack_i  = 1'b1;
                wbd.wbd_lack_i = (k == nb) && (nb > 1 || $urandom_range(0, 1) == 1);
            end
            @(posedge core_clk); #1;
            wbd.wbd_ack_i  = 1'b0;
            wbd.wbd_lack_i = 1'b0;
            wbd.wbd_err_i  = 1'b0;
            if (is_err) begin
                check_val("resp_err", 64'(core_dmem_resp), 64'(2 << (2 * g)));
                check_val("cyc_after_err", 64'(wbd.wbd_cyc_o), 64'(0));
                return;
            end
            check_val("resp_ok", 64'(core_dmem_resp), 64'(1 << (2 * g)));
            if (!wr) check_val("rdata", 64'(core_dmem_rdata), 64'(rd));
            check_val("cyc_after_beat", 64'(wbd.wbd_cyc_o), 64'(k < nb));
        end
    endtask

    initial begin
        core_rst_n      = 1'b0;
        core_dmem_req   = '0;
        core_dmem_cmd   = '0;
        core_dmem_width = '0;
        core_dmem_addr  = '0;
        core_dmem_bl    = '0;
        core_dmem_wdata = '0;
        wbd.wbd_dat_i   = '0;
        wbd.wbd_ack_i   = 1'b0;
        wbd.wbd_lack_i  = 1'b0;
        wbd.wbd_err_i   = 1'b0;

        repeat (2) @(posedge core_clk);
        #1;
        check_val("rst_req_ack", 64'(core_dmem_req_ack), 64'(0));
        check_val("rst_resp", 64'(core_dmem_resp), 64'(0));
        check_val("rst_rdata", 64'(core_dmem_rdata), 64'(0));
        check_val("rst_ctl", 64'({wbd.wbd_cyc_o, wbd.wbd_stb_o, wbd.wbd_we_o, wbd.wbd_bry_o}),
                  64'(0));
        check_val("rst_adr", 64'(wbd.wbd_adr_o), 64'(0));
        check_val("rst_sel_bl", 64'({wbd.wbd_sel_o, wbd.wbd_bl_o}), 64'(0));
        check_val("rst_dat_o", 64'(wbd.wbd_dat_o), 64'(0));
        core_rst_n = 1'b1;

        // Acks with no cycle in flight must be ignored.
        wbd.wbd_ack_i = 1'b1;
        wbd.wbd_dat_i = 32'h1234_5678;
        @(posedge core_clk); #1;
        wbd.wbd_ack_i = 1'b0;
        check_val("stray_ack_resp", 64'(core_dmem_resp), 64'(0));
        check_val("stray_ack_rdata", 64'(core_dmem_rdata), 64'(0));

        // Word read, slave answers after three idle cycles.
        set_req(0, 1'b0, 2'd2, 32'h100, BLW'(1), 32'h0);
        run_txn(0, 0, 3, 32'hDEAD_BEEF);
        // Byte write to the top lane.
        set_req(1, 1'b1, 2'd0, 32'h203, BLW'(5), 32'hAB00_0000);
        run_txn(0, 0, 1, 32'h0);
        // Misaligned word: error without a bus cycle.
        set_req(0, 1'b0, 2'd2, 32'h102, BLW'(1), 32'h0);
        run_txn(0, 0, -1, 32'h0);
        // Error on beat 2 of a 4-beat read.
        set_req(1, 1'b0, 2'd2, 32'h400, BLW'(4), 32'h0);
        run_txn(1, 2, -1, 32'h0);
        // Both channels requesting 4-beat reads continuously.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, 2'd2, 32'h1000, BLW'(4), 32'h0);
            set_req(1, 1'b0, 2'd2, 32'h2000, BLW'(4), 32'h0);
            run_txn(0, 0, -1, 32'h0);
        end
        core_dmem_req = '0;
        // Slave never answers.
        set_req(0, 1'b0, 2'd2, 32'h300, BLW'(1), 32'h0);
        run_txn(2, 0, -1, 32'h0);

        for (int i = 0; i < 250; i++) begin
            int r;
            for (int c = 0; c < int'(NCH); c++) begin
                if (!core_dmem_req[c] && $urandom_range(0, 1) == 1) rand_req(c);
            end
            if (core_dmem_req == '0) rand_req(int'($urandom_range(0, NCH - 1)));
            r = int'($urandom_range(0, 19));
            run_txn((r < 2) ? 1 : (r == 2) ? 2 : 0, 0, -1, 32'h0);
        end

        // Asynchronous reset in the middle of a burst.
        core_dmem_req = '0;
        set_req(0, 1'b0, 2'd2, 32'h40, BLW'(4), 32'h0);
        @(posedge core_clk); #1;
        check_val("cyc_pre_rst", 64'(wbd.wbd_cyc_o), 64'(1));
        core_dmem_req = '0;
        #2;
        core_rst_n = 1'b0;
        #1;
        check_val("rst_mid_ctl", 64'({wbd.wbd_cyc_o, wbd.wbd_stb_o, wbd.wbd_bry_o}), 64'(0));
        check_val("rst_mid_ack_resp", 64'({core_dmem_req_ack, core_dmem_resp}), 64'(0));
        check_val("rst_mid_adr", 64'(wbd.wbd_adr_o), 64'(0));
        @(posedge core_clk); #1;
        core_rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
